// File: rtl/mul_seq.sv
// Iterative WIDTH x WIDTH multiplier, signed or unsigned per transaction, with valid/ready on both sides.
// Define MUL_SEQ_BOOTH4_EN for radix-4 Booth recoding (WIDTH must then be even); default is radix-2 shift-add.
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
);

    localparam int PW = 2 * WIDTH;
`ifdef MUL_SEQ_BOOTH4_EN
    localparam int BW = WIDTH + 2;
`else
    localparam int BW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [BW-1:0]   r_mplier;
    logic            r_sgn;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_sum;
    logic [PW-1:0]   w_mcand_ext;
    logic [BW-1:0]   w_mplier_ext;
    logic [CW-1:0]   w_iter;
    logic            w_last;

    // The product is accumulated modulo 2^(2*WIDTH); the exact product always fits, so no overflow handling.
    assign w_mcand_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_last      = (r_cnt == CW'(1));

`ifdef MUL_SEQ_BOOTH4_EN
    logic       r_bprev;
    logic [2:0] w_grp;
    logic       w_neg;

    generate
        if (WIDTH % 2 != 0) begin : g_width_check
            $error("mul_seq: WIDTH must be even when MUL_SEQ_BOOTH4_EN is defined");
        end
    endgenerate

    assign w_mplier_ext = sgn ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign w_iter       = sgn ? CW'(WIDTH / 2) : CW'(WIDTH / 2 + 1);
    assign w_grp        = {r_mplier[1], r_mplier[0], r_bprev};

    always_comb begin
        w_pp  = '0;
        w_neg = 1'b0;
        case (w_grp)
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = r_mcand << 1;
            3'b100: begin
                w_pp  = r_mcand << 1;
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_pp  = r_mcand;
                w_neg = 1'b1;
            end
            default:        w_pp = '0;
        endcase
        w_sum = w_neg ? (r_acc - w_pp) : (r_acc + w_pp);
    end
`else
    assign w_mplier_ext = b;
    assign w_iter       = CW'(WIDTH);

    // In signed mode the top multiplier bit carries negative weight, so its partial product is subtracted.
    always_comb begin
        w_pp  = r_mplier[0] ? r_mcand : '0;
        w_sum = (r_sgn && w_last) ? (r_acc - w_pp) : (r_acc + w_pp);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z         <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_sgn     <= 1'b0;
            r_cnt     <= '0;
`ifdef MUL_SEQ_BOOTH4_EN
            r_bprev   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_mcand_ext;
                        r_mplier <= w_mplier_ext;
                        r_sgn    <= sgn;
                        r_acc    <= '0;
                        r_cnt    <= w_iter;
`ifdef MUL_SEQ_BOOTH4_EN
                        r_bprev  <= 1'b0;
`endif
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt - CW'(1);
`ifdef MUL_SEQ_BOOTH4_EN
                    r_mcand  <= r_mcand << 2;
                    r_mplier <= r_mplier >> 2;
                    r_bprev  <= r_mplier[1];
`else
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                    if (w_last) begin
                        z         <= w_sum;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and back-to-back checks for mul_seq at WIDTH=8 against hand-computed products and a small model.
module tb_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;

    int errors = 0;
    int checks = 0;

    mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input logic s);
`ifdef MUL_SEQ_BOOTH4_EN
        return s ? 4 : 5;
`else
        return 8;
`endif
    endfunction

    function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi;
        int yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        return 16'(xi * yi);
    endfunction

    // Presents one operand set, waits for acceptance, then counts edges until out_valid (left in DONE).
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          output logic [15:0] zout, output int lat, output bit timeout);
        int guard;
        a = x;
        b = y;
        sgn = s;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !out_valid;
        zout = z;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sgn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++;
        if (z !== 16'h0000) begin errors++; $display("[TB] FAIL reset_z: got %h, expected 0000", z); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_products();
        logic [7:0]  va [8] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h80};
        logic [7:0]  vb [8] = '{8'h80, 8'h80, 8'h01, 8'hFF, 8'hFF, 8'hAB, 8'hFF, 8'h7F};
        logic        vs [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] vz [8] = '{16'h4000, 16'hC080, 16'hFFFF, 16'hFE01, 16'h0001, 16'h0000, 16'h7F80, 16'hC080};
        logic [15:0] zout;
        int lat;
        bit timeout;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vs[i], zout, lat, timeout);
            checks++;
            if (timeout) begin errors++; $display("[TB] FAIL product_%0d_timeout: out_valid never rose", i); end
            checks++;
            if (zout !== vz[i]) begin errors++; $display("[TB] FAIL product_%0d_z: got %h, expected %h", i, zout, vz[i]); end
            checks++;
            if (lat !== exp_lat(vs[i])) begin errors++; $display("[TB] FAIL product_%0d_latency: got %0d, expected %0d", i, lat, exp_lat(vs[i])); end
            release_op();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL product_%0d_release: got out_valid=%b in_ready=%b, expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] zout;
        int lat;
        bit timeout;
        int bad;
        run_op(8'h12, 8'h34, 1'b0, zout, lat, timeout);
        checks++;
        if (timeout || zout !== 16'h03A8) begin errors++; $display("[TB] FAIL bp_z: got %h, expected 03a8", zout); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                a = 8'h99;
                b = 8'h77;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (z !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d bad cycles, expected 0", bad); end
        release_op();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_not_queued: got in_ready=%b, expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] zout;
        int lat;
        bit timeout;
        a = 8'h55;
        b = 8'h66;
        sgn = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || z !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got out_valid=%b z=%h, expected 0/0000", out_valid, z);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready: got %b, expected 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_partial: got out_valid=%b, expected 0", out_valid); end
        run_op(8'd3, 8'd5, 1'b0, zout, lat, timeout);
        checks++;
        if (timeout || zout !== 16'd15) begin errors++; $display("[TB] FAIL midreset_after_z: got %h, expected 000f", zout); end
        checks++;
        if (lat !== exp_lat(1'b0)) begin errors++; $display("[TB] FAIL midreset_after_latency: got %0d, expected %0d", lat, exp_lat(1'b0)); end
        release_op();
    endtask

    task automatic test_back_to_back();
        localparam int N = 1000;
        logic [15:0] expq [$];
        int   accepted;
        int   received;
        int   cycle;
        int   last_acc;
        logic last_sgn;
        bit   acc_now;
        int   spacing;
        a = 8'($urandom);
        b = 8'($urandom);
        sgn = 1'($urandom);
        in_valid = 1'b1;
        out_ready = 1'b1;
        accepted = 0;
        received = 0;
        cycle = 0;
        last_acc = 0;
        last_sgn = 1'b0;
        while (received < N && cycle < N * 16) begin
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            cycle++;
            if (acc_now) begin
                expq.push_back(model_mul(a, b, sgn));
                if (accepted > 0) begin
                    spacing = cycle - last_acc;
                    checks++;
                    if (spacing != exp_lat(last_sgn) + 2) begin
                        errors++;
                        $display("[TB] FAIL b2b_spacing_%0d: got %0d, expected %0d", accepted, spacing, exp_lat(last_sgn) + 2);
                    end
                end
                last_acc = cycle;
                last_sgn = sgn;
                accepted++;
                if (accepted >= N) in_valid = 1'b0;
                a = 8'($urandom);
                b = 8'($urandom);
                sgn = 1'($urandom);
            end
            if (out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL b2b_unexpected: got z=%h, expected no result", z);
                end else begin
                    if (z !== expq[0]) begin
                        errors++;
                        $display("[TB] FAIL b2b_z_%0d: got %h, expected %h", received, z, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                received++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (received != N) begin errors++; $display("[TB] FAIL b2b_count: got %0d results, expected %0d", received, N); end
    endtask

    initial begin
        test_reset();
        test_products();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
